// File: rtl/segre_assoc_tlb.sv
// segre_assoc_tlb: set-associative TLB with single-outstanding page-table-walk refill.
// Lookup happens combinationally on the accepted address; responses are registered.
// Optional feature: define SEGRE_TLB_PERF_EN to add 32-bit hit/miss counters.
module segre_assoc_tlb #(
    parameter int ENTRIES = 32,
    parameter int WAYS    = 4,
    parameter int VADDR_W = 32,
    parameter int PADDR_W = 20
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [VADDR_W-1:0]  vaddr_i,
    input  logic                store_i,
    output logic                resp_valid_o,
    output logic [PADDR_W-1:0]  paddr_o,
    output logic                fault_o,
    output logic                ptw_req_o,
    output logic [VADDR_W-13:0] ptw_vpn_o,
    input  logic                ptw_valid_i,
    input  logic [PADDR_W-13:0] ptw_ppn_i,
    input  logic [1:0]          ptw_perm_i,
    input  logic                flush_i
`ifdef SEGRE_TLB_PERF_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = VADDR_W - 12 - IDX_W;
    localparam int PPN_W = PADDR_W - 12;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

    state_t               state_q, state_d;
    logic [VADDR_W-1:0]   vaddr_q;
    logic                 store_q;

    logic [WAYS-1:0]      valid_q [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [PPN_W-1:0]     ppn_q   [SETS][WAYS];
    logic [1:0]           perm_q  [SETS][WAYS];
    logic [WAY_W-1:0]     rr_q    [SETS];

    logic [IDX_W-1:0]     lk_idx, rf_idx;
    logic [TAG_W-1:0]     lk_tag, rf_tag;
    logic                 hit;
    logic [PPN_W-1:0]     hit_ppn;
    logic [1:0]           hit_perm;
    logic [WAYS-1:0]      rf_valid;
    logic                 free_found;
    logic [WAY_W-1:0]     victim, rr_next;
    logic                 accept, refill;

    // A load needs R (bit 0), a store needs W (bit 1).
    function automatic logic perm_fault(input logic store, input logic [1:0] perm);
        return store ? !perm[1] : !perm[0];
    endfunction

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    assign refill      = (state_q == WALK) && ptw_valid_i;
    assign ptw_req_o   = (state_q == WALK);
    assign ptw_vpn_o   = vaddr_q[VADDR_W-1:12];

    assign lk_idx = vaddr_i[12 +: IDX_W];
    assign lk_tag = vaddr_i[VADDR_W-1 -: TAG_W];
    assign rf_idx = vaddr_q[12 +: IDX_W];
    assign rf_tag = vaddr_q[VADDR_W-1 -: TAG_W];

    // Lookup: scan from the top so the lowest matching way wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        hit      = 1'b0;
        hit_ppn  = '0;
        hit_perm = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                hit      = 1'b1;
                hit_ppn  = ppn_q[lk_idx][w];
                hit_perm = perm_q[lk_idx][w];
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer.
    // A simultaneous flush empties the set first, so way 0 is taken.
    always_comb begin
        rf_valid   = flush_i ? '0 : valid_q[rf_idx];
        free_found = 1'b0;
        victim     = rr_q[rf_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!rf_valid[w]) begin
                free_found = 1'b1;
                victim     = WAY_W'(w);
            end
        end
        rr_next = (rr_q[rf_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[rf_idx] + WAY_W'(1);
    end

    // Next-state logic: IDLE -> WALK on miss, WALK -> RESP on walk done, RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !hit) state_d = WALK;
            WALK:    if (ptw_valid_i)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, valid bits, round-robin pointers, request capture and response registers.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= IDLE;
            vaddr_q      <= '0;
            store_q      <= 1'b0;
            resp_valid_o <= 1'b0;
            paddr_o      <= '0;
            fault_o      <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            resp_valid_o <= 1'b0;
            paddr_o      <= '0;
            fault_o      <= 1'b0;
            if (accept) begin
                vaddr_q <= vaddr_i;
                store_q <= store_i;
                if (hit) begin
                    resp_valid_o <= 1'b1;
                    fault_o      <= perm_fault(store_i, hit_perm);
                    paddr_o      <= perm_fault(store_i, hit_perm) ? '0 : {hit_ppn, vaddr_i[11:0]};
                end
            end
            if (flush_i) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end
            // Refill is written after the flush clear so the new entry survives.
            if (refill) begin
                valid_q[rf_idx][victim] <= 1'b1;
                if (!free_found && !flush_i) rr_q[rf_idx] <= rr_next;
                resp_valid_o <= 1'b1;
                fault_o      <= perm_fault(store_q, ptw_perm_i);
                paddr_o      <= perm_fault(store_q, ptw_perm_i) ? '0 : {ptw_ppn_i, vaddr_q[11:0]};
            end
        end
    end

    // Translation payload storage, qualified by the valid bits.
    // NOTE: payload arrays are not reset; the valid bits alone decide whether an entry is usable.
    always_ff @(posedge clk_i) begin
        if (refill) begin
            tag_q[rf_idx][victim]  <= rf_tag;
            ppn_q[rf_idx][victim]  <= ptw_ppn_i;
            perm_q[rf_idx][victim] <= ptw_perm_i;
        end
    end

`ifdef SEGRE_TLB_PERF_EN
    // Performance counters: one increment per accepted request, wrapping at 2^32.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (accept) begin
            if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
            else     miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_segre_assoc_tlb.sv
// tb_segre_assoc_tlb: randomized scoreboard bench for segre_assoc_tlb (ENTRIES=32, WAYS=4).
// The driver issues requests and answers walks; a monitor pops expected responses.
module tb_segre_assoc_tlb;

    localparam int SETS = 8;
    localparam int WAYS = 4;

    logic        clk_i, rsn_i;
    logic        req_valid_i, req_ready_o;
    logic [31:0] vaddr_i;
    logic        store_i;
    logic        resp_valid_o;
    logic [19:0] paddr_o;
    logic        fault_o;
    logic        ptw_req_o;
    logic [19:0] ptw_vpn_o;
    logic        ptw_valid_i;
    logic [7:0]  ptw_ppn_i;
    logic [1:0]  ptw_perm_i;
    logic        flush_i;

    segre_assoc_tlb dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .vaddr_i(vaddr_i), .store_i(store_i),
        .resp_valid_o(resp_valid_o), .paddr_o(paddr_o), .fault_o(fault_o),
        .ptw_req_o(ptw_req_o), .ptw_vpn_o(ptw_vpn_o),
        .ptw_valid_i(ptw_valid_i), .ptw_ppn_i(ptw_ppn_i), .ptw_perm_i(ptw_perm_i),
        .flush_i(flush_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per set, WAYS slots holding full VPNs, plus a replacement pointer.
    bit         m_valid [SETS][WAYS];
    int         m_vpn   [SETS][WAYS];
    logic [7:0] m_ppn   [SETS][WAYS];
    logic [1:0] m_perm  [SETS][WAYS];
    int         m_ptr   [SETS];

    // Page table answered by the walker, filled lazily with random content.
    logic [7:0] pt_ppn  [int];
    logic [1:0] pt_perm [int];

    typedef struct {
        logic [19:0] paddr;
        logic        fault;
    } resp_t;
    resp_t exp_q[$];
    resp_t mon_r;

    function automatic int m_lookup(input int vpn);
        int s = vpn % SETS;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_vpn[s][w] == vpn) return w;
        return -1;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic m_insert(input int vpn, input logic [7:0] ppn, input logic [1:0] perm);
        int s = vpn % SETS;
        int v = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[s][v] = 1'b1;
        m_vpn[s][v]   = vpn;
        m_ppn[s][v]   = ppn;
        m_perm[s][v]  = perm;
    endtask

    task automatic pt_get(input int vpn, output logic [7:0] ppn, output logic [1:0] perm);
        if (!pt_ppn.exists(vpn)) begin
            pt_ppn[vpn]  = 8'($urandom);
            pt_perm[vpn] = 2'($urandom_range(0, 3));
        end
        ppn  = pt_ppn[vpn];
        perm = pt_perm[vpn];
    endtask

    function automatic resp_t make_resp(input logic [11:0] off, input logic [7:0] ppn,
                                        input logic [1:0] perm, input bit st);
        resp_t r;
        r.fault = st ? !perm[1] : !perm[0];
        r.paddr = r.fault ? 20'h0 : {ppn, off};
        return r;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk_i);
        check("req_ready", req_ready_o, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
        check("resp_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // flush_mode: 0 none, 1 flush in an earlier WALK cycle, 2 flush on the refill edge.
    task automatic do_req(input logic [31:0] va, input bit st, input int flush_mode);
        int vpn, s, way, d;
        logic [7:0] ppn;
        logic [1:0] perm;
        vpn = int'(va[31:12]);
        s   = vpn % SETS;
        wait_ready();
        way = m_lookup(vpn);
        if (way >= 0) exp_q.push_back(make_resp(va[11:0], m_ppn[s][way], m_perm[s][way], st));
        req_valid_i = 1'b1;
        vaddr_i     = va;
        store_i     = st;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        vaddr_i     = $urandom;
        store_i     = 1'($urandom_range(0, 1));
        if (way >= 0) begin
            check("ptw_req_on_hit", ptw_req_o, 0);
        end else begin
            check("ptw_req_on_miss", ptw_req_o, 1);
            check("ptw_vpn", ptw_vpn_o, vpn);
            d = (flush_mode == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                if (flush_mode == 1 && i == 0) begin
                    flush_i = 1'b1;
                    m_clear();
                end
                @(negedge clk_i);
                flush_i = 1'b0;
                check("ptw_req_held", ptw_req_o, 1);
                check("ptw_vpn_stable", ptw_vpn_o, vpn);
            end
            pt_get(vpn, ppn, perm);
            exp_q.push_back(make_resp(va[11:0], ppn, perm, st));
            ptw_valid_i = 1'b1;
            ptw_ppn_i   = ppn;
            ptw_perm_i  = perm;
            if (flush_mode == 2) flush_i = 1'b1;
            @(negedge clk_i);
            ptw_valid_i = 1'b0;
            flush_i     = 1'b0;
            ptw_ppn_i   = 8'($urandom);
            ptw_perm_i  = 2'($urandom);
            check("ptw_req_drop", ptw_req_o, 0);
            if (flush_mode == 2) m_clear();
            m_insert(vpn, ppn, perm);
        end
        wait_drain();
    endtask

    // Flush in IDLE with a request pending: the request must be refused.
    task automatic flush_idle();
        wait_ready();
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        vaddr_i     = $urandom;
        store_i     = 1'b0;
        #1 check("ready_blocked_by_flush", req_ready_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        m_clear();
        check("no_walk_after_flush", ptw_req_o, 0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic reset_in_walk(input logic [31:0] va);
        flush_idle();
        wait_ready();
        req_valid_i = 1'b1;
        vaddr_i     = va;
        store_i     = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("walk_before_reset", ptw_req_o, 1);
        #2 rsn_i = 1'b0;
        #1 check("ptw_req_async_reset", ptw_req_o, 0);
        check("resp_valid_in_reset", resp_valid_o, 0);
        m_clear();
        repeat (2) @(negedge clk_i);
        rsn_i = 1'b1;
        #1 check("ready_after_reset", req_ready_o, 1);
        repeat (3) @(negedge clk_i);
    endtask

    // Monitor: every response pulse must match the oldest expectation; outputs stay 0 otherwise.
    always @(negedge clk_i) begin
        if (rsn_i) begin
            if (resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", resp_valid_o, 0);
                end else begin
                    mon_r = exp_q.pop_front();
                    check("paddr", paddr_o, mon_r.paddr);
                    check("fault", fault_o, mon_r.fault);
                end
            end else begin
                check("idle_outputs_zero", {fault_o, paddr_o}, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        int vpn;
        int fm;
        rsn_i = 1'b0; req_valid_i = 1'b0; vaddr_i = '0; store_i = 1'b0;
        ptw_valid_i = 1'b0; ptw_ppn_i = '0; ptw_perm_i = '0; flush_i = 1'b0;
        m_clear();
        pt_ppn[5]     = 8'h2A; pt_perm[5]     = 2'b11;
        pt_ppn[8'h40] = 8'h77; pt_perm[8'h40] = 2'b01;
        pt_ppn[8'h41] = 8'h33; pt_perm[8'h41] = 2'b01;
        pt_ppn[8'h42] = 8'h44; pt_perm[8'h42] = 2'b10;

        #12;
        check("rst_req_ready", req_ready_o, 1);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_ptw_req", ptw_req_o, 0);
        check("rst_paddr", paddr_o, 0);
        check("rst_fault", fault_o, 0);
        @(negedge clk_i);
        rsn_i = 1'b1;

        // Cold miss then hit in the same page.
        do_req(32'h0000_5123, 1'b0, 0);
        do_req(32'h0000_5ABC, 1'b0, 0);
        // Fill set 5 and force a round-robin eviction of way 0.
        do_req(32'h0000_D000, 1'b0, 0);
        do_req(32'h0001_5000, 1'b0, 0);
        do_req(32'h0001_D000, 1'b0, 0);
        do_req(32'h0002_5000, 1'b0, 0);
        do_req(32'h0000_5000, 1'b0, 0);
        // Permission faults on hit and on refill.
        do_req(32'h0004_0010, 1'b0, 0);
        do_req(32'h0004_0020, 1'b1, 0);
        do_req(32'h0004_1000, 1'b1, 0);
        do_req(32'h0004_2000, 1'b0, 0);
        // Flushes: in IDLE, during WALK, and on the refill edge.
        flush_idle();
        do_req(32'h0000_5123, 1'b0, 1);
        do_req(32'h0000_5123, 1'b0, 0);
        do_req(32'h0001_5000, 1'b0, 2);
        do_req(32'h0001_5000, 1'b0, 0);
        do_req(32'h0000_5123, 1'b0, 0);
        // Reset while walking.
        reset_in_walk(32'h0000_7000);
        do_req(32'h0000_5123, 1'b0, 0);
        do_req(32'h0001_5000, 1'b0, 0);

        // Randomized traffic over a small VPN pool so sets fill and evict.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                flush_idle();
            end else begin
                vpn = $urandom_range(0, 70) | ($urandom_range(0, 1) << 17);
                fm  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
                do_req((32'(vpn) << 12) | 32'($urandom_range(0, 4095)),
                       1'($urandom_range(0, 1)), fm);
            end
        end

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/segre_assoc_tlb.md
SEGRE_ASSOC_TLB -- requirements
Module: segre_assoc_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 32: total translation entries (power of two).
REQ-002 SHALL have parameter WAYS, default 4: associativity (power of two, divides ENTRIES); SETS = ENTRIES/WAYS.
REQ-003 SHALL have parameter VADDR_W, default 32: virtual address width.
REQ-004 SHALL have parameter PADDR_W, default 20: physical address width; page offset fixed at 12 bits, PPN = PADDR_W-12 bits.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rsn_i  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  1  translation request; req_ready_o  out  1  request accepted when both high.
REQ-008 vaddr_i  in  VADDR_W  virtual address; store_i  in  1  request is a store.
REQ-009 resp_valid_o  out  1  one-cycle response pulse; paddr_o  out  PADDR_W  physical address; fault_o  out  1  permission fault.
REQ-010 ptw_req_o  out  1  walk request; ptw_vpn_o  out  VADDR_W-12  VPN to walk.
REQ-011 ptw_valid_i  in  1  walk done; ptw_ppn_i  in  PADDR_W-12  PPN; ptw_perm_i  in  2  bit0 R, bit1 W.
REQ-012 flush_i  in  1  invalidate all entries.

Function
REQ-013 Index = vaddr_i[12+log2(SETS)-1:12]; tag = vaddr_i[VADDR_W-1:12+log2(SETS)]; each way holds valid, tag, PPN, perm.
REQ-014 FSM states IDLE, WALK, RESP; req_ready_o = 1 only in IDLE with flush_i low.
REQ-015 IDLE, request accepted, hit: resp_valid_o pulses next cycle, paddr_o = {PPN, offset}; FSM stays IDLE.
REQ-016 IDLE, request accepted, miss: next cycle WALK, ptw_req_o = 1, ptw_vpn_o = vaddr_i[VADDR_W-1:12] held stable until ptw_valid_i.
REQ-017 WALK, ptw_valid_i = 1: entry written that edge, ptw_req_o drops, FSM to RESP; RESP pulses resp_valid_o with refilled translation, returns IDLE.
REQ-018 Accepted vaddr_i and store_i SHALL be registered; inputs ignored outside acceptance.
REQ-019 Victim: lowest-index invalid way in set; if none, per-set round-robin pointer way, pointer then increments modulo WAYS.
REQ-020 Fault: store_i with W = 0, or load with R = 0 -> fault_o = 1 with resp_valid_o, paddr_o = 0; entry stays valid.
REQ-021 fault_o and paddr_o SHALL be 0 whenever resp_valid_o = 0.
REQ-022 flush_i clears all valid bits and round-robin pointers in one cycle; in IDLE it blocks acceptance that cycle.
REQ-023 flush_i during WALK: walk continues, refill still written and response still delivered.
REQ-024 Flush and refill on same edge: flush clears all prior entries, refilled entry ends valid.
REQ-025 Multiple matching ways SHALL not occur; lookup uses lowest matching way.

Reset
REQ-026 rsn_i low SHALL asynchronously force FSM IDLE, all valid bits 0, pointers 0, outputs 0 except req_ready_o = 1.
REQ-027 Reset during WALK abandons walk; ptw_req_o drops immediately, no response issued.

Configuration
REQ-028 Macro SEGRE_TLB_PERF_EN defined: adds outputs hit_cnt_o and miss_cnt_o, 32 bits each, reset 0, wrap on overflow, increment once per accepted request.
REQ-029 Macro undefined: counters and ports absent; behaviour otherwise identical.

Verification (ENTRIES=32, WAYS=4: index vaddr[14:12], tag vaddr[31:15])
REQ-030 After reset, load 0x0000_5123 -> ptw_req_o=1, ptw_vpn_o=0x00005; return PPN 0x2A perm 2'b11 -> resp paddr_o=0x2A123, fault_o=0.
REQ-031 Then load 0x0000_5ABC -> resp_valid_o next cycle, paddr_o=0x2AABC, ptw_req_o never asserted.
REQ-032 Refill VPNs 0x05,0x0D,0x15,0x1D (same set) then 0x25 -> 0x25 replaces way 0; load 0x0000_5000 misses.
REQ-033 Store to page refilled with perm 2'b01 -> resp_valid_o=1, fault_o=1, paddr_o=0.
REQ-034 Pulse flush_i, load 0x0000_5123 -> miss and walk; flush_i during WALK -> response still delivered.
REQ-035 Drop rsn_i in WALK -> ptw_req_o=0 at once, no resp_valid_o; after release req_ready_o=1, all lookups miss.
